// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared types and constants for the dmac demux
// Contents:
//   slot_state_e : per-destination one-entry slot state
//   DROP_CNT_W   : width of the saturating dropped-beat counter
package dmac_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/dmac_demux_slot.sv
// rtl/dmac_demux_slot.sv - one-entry registered output slot for one destination
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : write data_i into the slot this cycle
//   data_i        : payload to capture
//   ready_i       : downstream accepts the held beat
//   valid_o       : slot holds a beat (S_FULL)
//   data_o        : held payload; keeps its last value after draining
module dmac_demux_slot
  import dmac_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATA_SIZE-1:0] data_o
);

  slot_state_e          state_q, state_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // The top only asserts load_i when the slot is empty or draining this
  // cycle, so a load never overwrites a beat that was not taken.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      S_EMPTY: begin
        if (load_i) begin
          state_d = S_FULL;
          data_d  = data_i;
        end
      end
      S_FULL: begin
        if (load_i) begin
          state_d = S_FULL;
          data_d  = data_i;
        end else if (ready_i) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign valid_o = (state_q == S_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/dmac_demux.sv
// rtl/dmac_demux.sv - routes source beats to N_SLAVE registered destination slots
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   src_valid_i/ready_o : source handshake
//   src_id_i, src_data_i: destination index and payload
//   dst_valid_o/ready_i : per-destination handshake
//   dst_data_o          : per-destination registered payload
//   err_o               : one-cycle pulse after a beat with an out-of-range id is dropped
//   drop_cnt_o          : saturating count of dropped beats
module dmac_demux
  import dmac_pkg::*;
#(
  parameter int N_SLAVE   = 4,
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [ID_SIZE-1:0]    src_id_i,
  input  logic [DATA_SIZE-1:0]  src_data_i,
  output logic [N_SLAVE-1:0]    dst_valid_o,
  input  logic [N_SLAVE-1:0]    dst_ready_i,
  output logic [DATA_SIZE-1:0]  dst_data_o [N_SLAVE],
  output logic                  err_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  logic [N_SLAVE-1:0]    load;
  logic                  id_ok;
  logic                  ready_sel;
  logic                  drop;
  logic                  err_q, err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign id_ok = ({{(32-ID_SIZE){1'b0}}, src_id_i} < 32'(N_SLAVE));

  // Ready depends only on the id and the addressed slot, never on src_valid_i.
  // An out-of-range id is always ready so the bad beat can be swallowed.
  always_comb begin
    ready_sel = 1'b1;
    load      = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (src_id_i == ID_SIZE'(i)) begin
        ready_sel = ~dst_valid_o[i] | dst_ready_i[i];
        load[i]   = src_valid_i & (~dst_valid_o[i] | dst_ready_i[i]);
      end
    end
  end

  assign src_ready_o = ready_sel;
  assign drop        = src_valid_i & ~id_ok;

  for (genvar g = 0; g < N_SLAVE; g++) begin : g_slot
    dmac_demux_slot #(
      .DATA_SIZE(DATA_SIZE)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[g]),
      .data_i (src_data_i),
      .ready_i(dst_ready_i[g]),
      .valid_o(dst_valid_o[g]),
      .data_o (dst_data_o[g])
    );
  end

  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_dmac_demux.sv
// tb/tb_dmac_demux.sv - directed self-checking bench for dmac_demux
module tb_dmac_demux;

  logic clk;
  logic rst_n;

  // Instance a: default N_SLAVE=4
  logic        a_valid;
  logic        a_ready;
  logic [1:0]  a_id;
  logic [31:0] a_data_in;
  logic [3:0]  a_dvalid;
  logic [3:0]  a_dready;
  logic [31:0] a_ddata [4];
  logic        a_err;
  logic [15:0] a_cnt;

  // Instance b: N_SLAVE=3 so id=3 is out of range
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_id;
  logic [31:0] b_data_in;
  logic [2:0]  b_dvalid;
  logic [2:0]  b_dready;
  logic [31:0] b_ddata [3];
  logic        b_err;
  logic [15:0] b_cnt;

  int checks;
  int failures;

  dmac_demux #(.N_SLAVE(4), .DATA_SIZE(32)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid_i(a_valid),
    .src_ready_o(a_ready),
    .src_id_i   (a_id),
    .src_data_i (a_data_in),
    .dst_valid_o(a_dvalid),
    .dst_ready_i(a_dready),
    .dst_data_o (a_ddata),
    .err_o      (a_err),
    .drop_cnt_o (a_cnt)
  );

  dmac_demux #(.N_SLAVE(3), .DATA_SIZE(32)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid_i(b_valid),
    .src_ready_o(b_ready),
    .src_id_i   (b_id),
    .src_data_i (b_data_in),
    .dst_valid_o(b_dvalid),
    .dst_ready_i(b_dready),
    .dst_data_o (b_ddata),
    .err_o      (b_err),
    .drop_cnt_o (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    a_id      = 2'd0;
    a_data_in = '0;
    a_dready  = '0;
    b_valid   = 1'b0;
    b_id      = 2'd0;
    b_data_in = '0;
    b_dready  = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_dvalid", 64'(a_dvalid), 64'h0);
    check_eq("rst_data2", 64'(a_ddata[2]), 64'h0);
    check_eq("rst_err", 64'(b_err), 64'h0);
    check_eq("rst_cnt", 64'(b_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single beat to port 2 with every destination stalled
    a_valid = 1'b1; a_id = 2'd2; a_data_in = 32'hA5A5_0002;
    #1;
    check_eq("single_ready_empty", 64'(a_ready), 64'h1);
    step();
    a_valid = 1'b0;
    #1;
    check_eq("single_dvalid", 64'(a_dvalid), 64'h4);
    check_eq("single_data", 64'(a_ddata[2]), 64'hA5A5_0002);
    check_eq("single_ready_full", 64'(a_ready), 64'h0);
    step();
    check_eq("single_hold_valid", 64'(a_dvalid), 64'h4);
    check_eq("single_ready_stall", 64'(a_ready), 64'h0);
    a_dready = 4'b0100;
    #1;
    check_eq("single_ready_drain", 64'(a_ready), 64'h1);
    step();
    a_dready = 4'b0000;
    #1;
    check_eq("single_drained", 64'(a_dvalid), 64'h0);
    check_eq("single_data_kept", 64'(a_ddata[2]), 64'hA5A5_0002);

    // Back-to-back: 8 beats to port 1 with ready held
    a_dready = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1; a_id = 2'd1; a_data_in = 32'h0000_0100 + 32'(k);
      #1;
      check_eq($sformatf("b2b_ready_%0d", k), 64'(a_ready), 64'h1);
      step();
      check_eq($sformatf("b2b_valid_%0d", k), 64'(a_dvalid), 64'h2);
      check_eq($sformatf("b2b_data_%0d", k), 64'(a_ddata[1]), 64'(32'h0000_0100 + 32'(k)));
    end
    a_valid = 1'b0;
    step();
    check_eq("b2b_drained", 64'(a_dvalid), 64'h0);
    a_dready = 4'b0000;

    // Head-of-line isolation: port 0 full and stalled
    a_valid = 1'b1; a_id = 2'd0; a_data_in = 32'h0000_00AA;
    step();
    a_data_in = 32'h0000_00BB;
    #1;
    check_eq("hol_ready_id0", 64'(a_ready), 64'h0);
    step();
    check_eq("hol_data0_held", 64'(a_ddata[0]), 64'h0000_00AA);
    check_eq("hol_valid_id0_only", 64'(a_dvalid), 64'h1);
    a_id = 2'd3; a_data_in = 32'h0000_0033;
    #1;
    check_eq("hol_ready_id3", 64'(a_ready), 64'h1);
    step();
    a_valid = 1'b0;
    #1;
    check_eq("hol_valid", 64'(a_dvalid), 64'h9);
    check_eq("hol_data3", 64'(a_ddata[3]), 64'h0000_0033);
    check_eq("hol_data0", 64'(a_ddata[0]), 64'h0000_00AA);

    // Reset mid-operation: fill port 1 too, then reset between edges
    a_valid = 1'b1; a_id = 2'd1; a_data_in = 32'h0000_0011;
    step();
    a_valid = 1'b0;
    #1;
    check_eq("midrst_pre_valid", 64'(a_dvalid), 64'hB);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(a_dvalid), 64'h0);
    check_eq("midrst_data0", 64'(a_ddata[0]), 64'h0);
    check_eq("midrst_data1", 64'(a_ddata[1]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_id = 2'd1; a_data_in = 32'h0000_5555;
    #1;
    check_eq("postrst_ready", 64'(a_ready), 64'h1);
    step();
    a_valid = 1'b0;
    #1;
    check_eq("postrst_valid", 64'(a_dvalid), 64'h2);
    check_eq("postrst_data", 64'(a_ddata[1]), 64'h0000_5555);

    // Bad id on the 3-port instance
    b_valid = 1'b1; b_id = 2'd3; b_data_in = 32'hDEAD_BEEF;
    #1;
    check_eq("bad_ready", 64'(b_ready), 64'h1);
    step();
    b_valid = 1'b0;
    #1;
    check_eq("bad_err", 64'(b_err), 64'h1);
    check_eq("bad_no_dvalid", 64'(b_dvalid), 64'h0);
    check_eq("bad_cnt1", 64'(b_cnt), 64'h1);
    step();
    check_eq("bad_err_pulse", 64'(b_err), 64'h0);
    check_eq("bad_cnt_hold", 64'(b_cnt), 64'h1);

    // A valid beat on the 3-port instance still routes normally
    b_valid = 1'b1; b_id = 2'd2; b_data_in = 32'h0000_0222;
    step();
    b_valid = 1'b0;
    #1;
    check_eq("b_good_valid", 64'(b_dvalid), 64'h4);
    check_eq("b_good_err", 64'(b_err), 64'h0);

    // 65535 further bad beats: 65536 total saturates at FFFF
    b_valid = 1'b1; b_id = 2'd3;
    for (int k = 0; k < 65535; k++) begin
      step();
    end
    check_eq("sat_err_streaming", 64'(b_err), 64'h1);
    check_eq("sat_cnt", 64'(b_cnt), 64'hFFFF);
    step();
    b_valid = 1'b0;
    #1;
    check_eq("sat_cnt_hold", 64'(b_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmac_demux.md
DMAC_DEMUX -- requirements
Module: dmac_demux

Interface
REQ-001 The block SHALL have parameter N_SLAVE, default 4: number of destination ports (2..16).
REQ-002 The block SHALL have parameter DATA_SIZE, default 32: payload width in bits.
REQ-003 The block SHALL have derived parameter ID_SIZE = $clog2(N_SLAVE), minimum 1: width of the routing ID.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 src_valid_i  input  1  source beat valid.
REQ-007 src_ready_o  output  1  block accepts the beat this cycle.
REQ-008 src_id_i  input  ID_SIZE  destination port index for the beat.
REQ-009 src_data_i  input  DATA_SIZE  beat payload.
REQ-010 dst_valid_o[N_SLAVE]  output  1 each  registered valid per destination.
REQ-011 dst_ready_i[N_SLAVE]  input  1 each  destination accepts.
REQ-012 dst_data_o[N_SLAVE]  output  DATA_SIZE each  registered payload per destination.
REQ-013 err_o  output  1  one-cycle pulse: a beat with src_id_i >= N_SLAVE was dropped.
REQ-014 drop_cnt_o  output  16  count of dropped beats, saturating.

Function
REQ-015 Each destination SHALL own a one-entry slot with states S_EMPTY and S_FULL; dst_valid_o[i] SHALL be 1 exactly when slot i is S_FULL.
REQ-016 src_ready_o SHALL be 1 when src_id_i < N_SLAVE and (slot[src_id_i] is S_EMPTY or dst_ready_i[src_id_i] is 1); it SHALL be 1 when src_id_i >= N_SLAVE; it SHALL NOT depend on src_valid_i.
REQ-017 A beat SHALL be accepted when src_valid_i and src_ready_o are both 1 in the same cycle.
REQ-018 An accepted beat with a valid ID SHALL appear on dst_valid_o/dst_data_o of that port on the next cycle (latency 1).
REQ-019 Slot transitions: S_EMPTY + load -> S_FULL; S_FULL + dst_ready_i without load -> S_EMPTY; S_FULL + dst_ready_i + load -> S_FULL with the new data; S_FULL without dst_ready_i -> S_FULL with data held.
REQ-020 Once asserted, dst_valid_o[i] and dst_data_o[i] SHALL stay stable until the cycle in which dst_ready_i[i] is 1.
REQ-021 dst_data_o[i] SHALL keep its last value after the slot drains; it is not cleared.
REQ-022 Each port SHALL sustain one beat per cycle when its dst_ready_i is held at 1.
REQ-023 Per-port order SHALL equal source acceptance order; a stalled port SHALL NOT block beats routed to other ports.
REQ-024 An accepted beat with src_id_i >= N_SLAVE SHALL be discarded; err_o SHALL pulse high on the following cycle; drop_cnt_o SHALL increment by one and saturate at 16'hFFFF.
REQ-025 No combinational path SHALL exist from src_valid_i or src_data_i to any dst_* output.

Reset
REQ-026 While rst_n is 0, all slots SHALL be S_EMPTY, every dst_valid_o SHALL be 0, every dst_data_o SHALL be 0, err_o SHALL be 0, and drop_cnt_o SHALL be 0, independent of clk.
REQ-027 A reset asserted mid-transfer SHALL discard held beats with no partial delivery; the first acceptance after release SHALL behave as from the empty state.

Structure
REQ-028 The slot state enum (S_EMPTY, S_FULL) and the drop-counter width constant SHALL live in shared package DMAC_PKG.
REQ-029 The one-entry slot SHALL be a sub-module, dmac_demux_slot, instantiated N_SLAVE times by a generate loop; decode, error pulse and counter SHALL stay in the top level.

Verification
REQ-030 Single beat: id=2, data=32'hA5A5_0002, all dst_ready_i=0 -> next cycle dst_valid_o[2]=1 with that data, other ports 0; src_ready_o for id=2 drops to 0 until dst_ready_i[2]=1.
REQ-031 Back-to-back: 8 beats to id=1 with dst_ready_i[1]=1 held -> 8 consecutive dst_valid_o[1] cycles, data in order, src_ready_o held at 1.
REQ-032 Head-of-line isolation: port 0 full and stalled, then beats to id=0, id=3 -> id=0 sees src_ready_o=0; after id switches to 3, the id=3 beat is accepted and delivered one cycle later.
REQ-033 Bad ID with N_SLAVE=3: id=3, data=32'hDEAD_BEEF -> accepted, no dst_valid_o asserted, err_o high for exactly one cycle, drop_cnt_o becomes 1; 65536 bad beats leave drop_cnt_o at 16'hFFFF.
REQ-034 Reset mid-operation: ports 0 and 1 full, rst_n pulled low between clock edges -> all dst_valid_o go 0 immediately; after release, a beat to id=1 is delivered normally with the new data.
